// File: rtl/ball_motion.sv
// Ball motion engine for the sprite renderer.
// Advances the ball sprite once per frame tick, bounces it off the top and bottom walls and off
// both paddles, detects misses (score pulses) and re-serves from screen centre after a hold-off.
// Optional: define BALL_SPEEDUP_EN to add one pixel of horizontal step per paddle hit,
// saturating at twice the base step. The step returns to base on serve and on reset.
// The sprite record is flattened onto plain ports: x_pos, y_pos, right, bottom.
module ball_motion #(
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned BALL_SIZE      = 8,
  parameter int unsigned SPEED_X        = 2,
  parameter int unsigned SPEED_Y        = 2,
  parameter int unsigned PADDLE_W       = 8,
  parameter int unsigned PADDLE_H       = 64,
  parameter int unsigned LEFT_PADDLE_X  = 16,
  parameter int unsigned RIGHT_PADDLE_X = 616,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned X_POS_W        = 10,
  parameter int unsigned Y_POS_W        = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic [Y_POS_W-1:0] left_paddle_y_i,
  input  logic [Y_POS_W-1:0] right_paddle_y_i,
  output logic               score_left_o,
  output logic               score_right_o,
  output logic               hit_o,
  output logic [X_POS_W-1:0] sprite_x_pos_o,
  output logic [Y_POS_W-1:0] sprite_y_pos_o,
  output logic [X_POS_W-1:0] sprite_right_o,
  output logic [Y_POS_W-1:0] sprite_bottom_o
);

  // One extra bit of headroom so sums and differences never wrap.
  localparam int unsigned XW   = X_POS_W + 1;
  localparam int unsigned YW   = Y_POS_W + 1;
  localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);

  localparam logic [XW-1:0] XMax        = XW'(SCREEN_W - 1 - BALL_SIZE);
  localparam logic [YW-1:0] YMax        = YW'(SCREEN_H - 1 - BALL_SIZE);
  localparam logic [XW-1:0] XCentre     = XW'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [YW-1:0] YCentre     = YW'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [XW-1:0] LeftEdgeX   = XW'(LEFT_PADDLE_X);
  localparam logic [XW-1:0] LeftBounceX = XW'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [XW-1:0] RightEdgeX  = XW'(RIGHT_PADDLE_X);
  localparam logic [XW-1:0] RightBounce = XW'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [XW-1:0] BallX       = XW'(BALL_SIZE);
  localparam logic [YW-1:0] BallY       = YW'(BALL_SIZE);
  localparam logic [YW-1:0] PaddleH     = YW'(PADDLE_H);
  localparam logic [YW-1:0] StepY       = YW'(SPEED_Y);
  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_FRAMES);

  typedef enum logic [0:0] {StServe, StMove} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [X_POS_W-1:0] x_q, x_d;
  logic [Y_POS_W-1:0] y_q, y_d;
  logic [X_POS_W-1:0] right_q, right_d;
  logic [Y_POS_W-1:0] bottom_q, bottom_d;
  logic               dir_x_q, dir_x_d;   // 1: moving right
  logic               dir_y_q, dir_y_d;   // 1: moving down
  logic               hit_q, hit_d;
  logic               score_left_q, score_left_d;
  logic               score_right_q, score_right_d;

  logic [XW-1:0] x_ext;
  logic [YW-1:0] y_ext;
  logic [YW-1:0] lp_ext;
  logic [YW-1:0] rp_ext;
  logic [XW-1:0] step_x;
  logic          overlap_l;
  logic          overlap_r;
  logic          hit_l;
  logic          hit_r;

`ifdef BALL_SPEEDUP_EN
  localparam int unsigned      StepW   = $clog2(2 * SPEED_X + 1);
  localparam logic [StepW-1:0] StepMin = StepW'(SPEED_X);
  localparam logic [StepW-1:0] StepMax = StepW'(2 * SPEED_X);

  logic [StepW-1:0] step_q, step_d;

  assign step_x = XW'(step_q);
`else
  assign step_x = XW'(SPEED_X);
`endif

  assign x_ext  = {1'b0, x_q};
  assign y_ext  = {1'b0, y_q};
  assign lp_ext = {1'b0, left_paddle_y_i};
  assign rp_ext = {1'b0, right_paddle_y_i};

  // Paddle contact tests, all evaluated on the pre-tick position.
  always_comb begin
    overlap_l = (y_ext + BallY >= lp_ext) && (y_ext <= lp_ext + PaddleH);
    overlap_r = (y_ext + BallY >= rp_ext) && (y_ext <= rp_ext + PaddleH);
    hit_l     = overlap_l && (x_ext <= LeftBounceX + step_x) && (x_ext > LeftEdgeX);
    hit_r     = overlap_r && (x_ext + BallX + step_x >= RightEdgeX) && (x_ext < RightEdgeX);
  end

  // Per-tick motion: serve hold-off, wall bounce, paddle bounce and miss detection.
  always_comb begin
    logic restart;
    restart       = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    hit_d         = 1'b0;
    score_left_d  = 1'b0;
    score_right_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
    step_d        = step_q;
`endif

    if (frame_tick_i) begin
      unique case (state_q)
        StServe: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == ServeLast) begin
            state_d = StMove;
          end
        end
        StMove: begin
          if (dir_y_q) begin
            if (y_ext + StepY > YMax) begin
              y_d     = Y_POS_W'(YMax);
              dir_y_d = 1'b0;
            end else begin
              y_d = Y_POS_W'(y_ext + StepY);
            end
          end else begin
            if (y_ext < StepY) begin
              y_d     = '0;
              dir_y_d = 1'b1;
            end else begin
              y_d = Y_POS_W'(y_ext - StepY);
            end
          end

          // Paddle hit wins over a miss on the same tick.
          if (!dir_x_q) begin
            if (hit_l) begin
              x_d     = X_POS_W'(LeftBounceX);
              dir_x_d = 1'b1;
              hit_d   = 1'b1;
            end else if (x_ext < step_x) begin
              score_right_d = 1'b1;
              dir_x_d       = 1'b0;
              restart       = 1'b1;
            end else begin
              x_d = X_POS_W'(x_ext - step_x);
            end
          end else begin
            if (hit_r) begin
              x_d     = X_POS_W'(RightBounce);
              dir_x_d = 1'b0;
              hit_d   = 1'b1;
            end else if (x_ext + step_x > XMax) begin
              score_left_d = 1'b1;
              dir_x_d      = 1'b1;
              restart      = 1'b1;
            end else begin
              x_d = X_POS_W'(x_ext + step_x);
            end
          end

`ifdef BALL_SPEEDUP_EN
          if (hit_d && (step_q < StepMax)) begin
            step_d = step_q + StepW'(1);
          end
`endif

          // Serve goes toward the player who just conceded.
          if (restart) begin
            state_d = StServe;
            cnt_d   = '0;
            x_d     = X_POS_W'(XCentre);
            y_d     = Y_POS_W'(YCentre);
`ifdef BALL_SPEEDUP_EN
            step_d  = StepMin;
`endif
          end
        end
      endcase
    end

    // Renderer draws strictly inside the bounds, hence the +1.
    right_d  = x_d + X_POS_W'(BALL_SIZE + 1);
    bottom_d = y_d + Y_POS_W'(BALL_SIZE + 1);
  end

  // State and registered sprite/pulse outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StServe;
      cnt_q         <= '0;
      x_q           <= X_POS_W'(XCentre);
      y_q           <= Y_POS_W'(YCentre);
      right_q       <= X_POS_W'(XCentre + BallX + XW'(1));
      bottom_q      <= Y_POS_W'(YCentre + BallY + YW'(1));
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      hit_q         <= 1'b0;
      score_left_q  <= 1'b0;
      score_right_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      step_q        <= StepMin;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      right_q       <= right_d;
      bottom_q      <= bottom_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      hit_q         <= hit_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
`ifdef BALL_SPEEDUP_EN
      step_q        <= step_d;
`endif
    end
  end

  assign sprite_x_pos_o  = x_q;
  assign sprite_y_pos_o  = y_q;
  assign sprite_right_o  = right_q;
  assign sprite_bottom_o = bottom_q;
  assign hit_o           = hit_q;
  assign score_left_o    = score_left_q;
  assign score_right_o   = score_right_q;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: randomized paddle stimulus against a behavioural model
// of the ball written with plain integer arithmetic.
module tb_ball_motion;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       frame_tick_i = 1'b0;
  logic [8:0] left_paddle_y_i = '0;
  logic [8:0] right_paddle_y_i = '0;
  logic       score_left_o;
  logic       score_right_o;
  logic       hit_o;
  logic [9:0] x_o;
  logic [8:0] y_o;
  logic [9:0] right_o;
  logic [8:0] bottom_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int mx, my, mcnt, mstep;
  bit mdx, mdy, mserve;
  bit exp_hit, exp_sl, exp_sr;
  int mode;  // 0: paddles away, 1: random paddles, 2: paddles track the ball

`ifdef BALL_SPEEDUP_EN
  localparam int MaxStep = 4;
`else
  localparam int MaxStep = 2;
`endif

  ball_motion dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .frame_tick_i     (frame_tick_i),
    .left_paddle_y_i  (left_paddle_y_i),
    .right_paddle_y_i (right_paddle_y_i),
    .score_left_o     (score_left_o),
    .score_right_o    (score_right_o),
    .hit_o            (hit_o),
    .sprite_x_pos_o   (x_o),
    .sprite_y_pos_o   (y_o),
    .sprite_right_o   (right_o),
    .sprite_bottom_o  (bottom_o)
  );

  always #5 clk_i = ~clk_i;

  wire [40:0] obs = {x_o, y_o, right_o, bottom_o, hit_o, score_left_o, score_right_o};

  function automatic logic [40:0] exp_vec();
    return {10'(mx), 9'(my), 10'(mx + 9), 9'(my + 9), exp_hit, exp_sl, exp_sr};
  endfunction

  function automatic int pick_paddle(input int y, input int m);
    int p;
    if (m == 2) begin
      p = y - int'($urandom_range(0, 60));
      if (p < 0) p = 0;
    end else if (m == 1) begin
      p = int'($urandom_range(0, 511));
    end else begin
      p = (y >= 240) ? 0 : 400;
    end
    return p;
  endfunction

  task automatic model_reset();
    mx = 316; my = 236; mdx = 1; mdy = 1;
    mserve = 1; mcnt = 0; mstep = 2;
    exp_hit = 0; exp_sl = 0; exp_sr = 0;
  endtask

  // One frame of the game as the rules describe it, on the old position.
  task automatic model_tick(input int lp, input int rp);
    int nx, ny;
    bit ndy, ol, orr;
    exp_hit = 0; exp_sl = 0; exp_sr = 0;
    if (mserve) begin
      mcnt++;
      if (mcnt >= 60) mserve = 0;
    end else begin
      ndy = mdy;
      if (mdy) begin
        if (my + 2 > 471) begin ny = 471; ndy = 0; end
        else ny = my + 2;
      end else begin
        if (my - 2 < 0) begin ny = 0; ndy = 1; end
        else ny = my - 2;
      end
      ol  = (my + 8 >= lp) && (my <= lp + 64);
      orr = (my + 8 >= rp) && (my <= rp + 64);
      nx = mx;
      if (!mdx) begin
        if (ol && (mx - mstep <= 24) && (mx > 16)) begin
          nx = 24; mdx = 1; exp_hit = 1;
        end else if (mx - mstep < 0) begin
          exp_sr = 1; mdx = 0;
        end else nx = mx - mstep;
      end else begin
        if (orr && (mx + 8 + mstep >= 616) && (mx < 616)) begin
          nx = 608; mdx = 0; exp_hit = 1;
        end else if (mx + mstep > 631) begin
          exp_sl = 1; mdx = 1;
        end else nx = mx + mstep;
      end
      mdy = ndy;
      if (exp_hit && mstep < MaxStep) mstep++;
      if (exp_sl || exp_sr) begin
        mserve = 1; mcnt = 0; nx = 316; ny = 236; mstep = 2;
      end
      mx = nx; my = ny;
    end
  endtask

  // Pulse the tick for one cycle; paddle inputs are scrambled off the tick cycle.
  task automatic do_tick(input int lp, input int rp);
    @(negedge clk_i);
    left_paddle_y_i  = 9'(lp);
    right_paddle_y_i = 9'(rp);
    frame_tick_i     = 1'b1;
    @(negedge clk_i);
    frame_tick_i     = 1'b0;
    left_paddle_y_i  = 9'($urandom);
    right_paddle_y_i = 9'($urandom);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    frame_tick_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL reset_state got=%h want=%h", obs, exp_vec());
    end
    total++;
    if (x_o !== 10'd316 || y_o !== 9'd236 || right_o !== 10'd325 || bottom_o !== 9'd245) begin
      bad++; $display("FAIL reset_centre got=%0d,%0d,%0d,%0d want=316,236,325,245",
                      x_o, y_o, right_o, bottom_o);
    end
  endtask

  task automatic test_serve();
    for (int t = 1; t <= 61; t++) begin
      do_tick(200, 200);
      model_tick(200, 200);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL serve_tick%0d got=%h want=%h", t, obs, exp_vec());
      end
    end
    total++;
    if (x_o !== 10'd318 || y_o !== 9'd238) begin
      bad++; $display("FAIL serve_first_move got=%0d,%0d want=318,238", x_o, y_o);
    end
  endtask

  task automatic test_rally(input int n);
    int lp, rp, r;
    bit was_serve;
    mode = 2;
    for (int t = 0; t < n; t++) begin
      lp = pick_paddle(my, mode);
      rp = pick_paddle(my, mode);
      was_serve = mserve;
      do_tick(lp, rp);
      model_tick(lp, rp);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL rally_tick%0d got=%h want=%h", t, obs, exp_vec());
      end
      if (exp_hit || (was_serve && !mserve)) begin
        r = int'($urandom_range(0, 5));
        mode = (r >= 2) ? 2 : r;
      end
      // Pulses drop after one cycle and the position holds between ticks.
      @(negedge clk_i);
      exp_hit = 0; exp_sl = 0; exp_sr = 0;
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL rally_hold%0d got=%h want=%h", t, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_move();
    logic [40:0] rst_vec;
    int lp, rp;
    rst_vec = {10'd316, 9'd236, 10'd325, 9'd245, 3'b000};
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    for (int t = 0; t < 400 && !(mdx && !mserve && mx >= 500); t++) begin
      lp = pick_paddle(my, 2);
      rp = pick_paddle(my, 2);
      do_tick(lp, rp);
      model_tick(lp, rp);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL midrst_run%0d got=%h want=%h", t, obs, exp_vec());
      end
    end
    total++;
    if (x_o < 10'd500) begin
      bad++; $display("FAIL midrst_reach got=%0d want>=500", x_o);
    end
    // Reset lands together with a tick: the tick must be ignored.
    @(negedge clk_i);
    rst_i = 1'b1;
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    total++;
    if (obs !== rst_vec) begin
      bad++; $display("FAIL midrst_values got=%h want=%h", obs, rst_vec);
    end
    for (int k = 0; k < 3; k++) begin
      do_tick(0, 0);
      total++;
      if (obs !== rst_vec) begin
        bad++; $display("FAIL midrst_tick_in_reset%0d got=%h want=%h", k, obs, rst_vec);
      end
    end
    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    total++;
    if (obs !== rst_vec) begin
      bad++; $display("FAIL midrst_release got=%h want=%h", obs, rst_vec);
    end
  endtask

`ifdef BALL_SPEEDUP_EN
  task automatic test_speedup();
    int hits, dx, xo, lp, rp, want;
    bit pend, scored, armed, done;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    hits = 0; pend = 0;
    for (int t = 0; t < 2000 && !(hits == 3 && !pend); t++) begin
      xo = int'(x_o);
      lp = pick_paddle(my, 2);
      rp = pick_paddle(my, 2);
      do_tick(lp, rp);
      model_tick(lp, rp);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL speedup_track%0d got=%h want=%h", t, obs, exp_vec());
      end
      if (pend) begin
        dx = int'(x_o) - xo;
        if (dx < 0) dx = -dx;
        want = (hits + 2 > 4) ? 4 : hits + 2;
        total++;
        if (dx != want) begin
          bad++; $display("FAIL speedup_step_after_hit%0d got=%0d want=%0d", hits, dx, want);
        end
        pend = 0;
      end
      if (hit_o) begin hits++; pend = 1; end
    end
    total++;
    if (hits != 3) begin
      bad++; $display("FAIL speedup_hit_budget got=%0d want=3", hits);
    end
    // Let the ball go, then the new serve must start at the base step.
    scored = 0; armed = 0; done = 0;
    for (int t = 0; t < 1500 && !done; t++) begin
      xo = int'(x_o);
      lp = pick_paddle(my, 0);
      rp = pick_paddle(my, 0);
      do_tick(lp, rp);
      model_tick(lp, rp);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL speedup_miss%0d got=%h want=%h", t, obs, exp_vec());
      end
      if (armed) begin
        dx = int'(x_o) - xo;
        if (dx < 0) dx = -dx;
        total++;
        if (dx != 2) begin
          bad++; $display("FAIL speedup_serve_step got=%0d want=2", dx);
        end
        done = 1;
      end
      if (score_left_o || score_right_o) scored = 1;
      if (scored && !mserve && !armed && !done) armed = 1;
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL speedup_serve_budget got=0 want=1");
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_serve();
    test_rally(2500);
    test_reset_mid_move();
`ifdef BALL_SPEEDUP_EN
    test_speedup();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
